logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the 16-bit bitwise AND gate.
- Computes one of eight bitwise operations on two WIDTH-bit operands.
- Result is held in a one-stage output register with valid/ready handshakes on both sides, plus zero and negative flags in the style of the ALU.
- Chain mode uses the previous result as operand A, so multi-step bitwise reductions stream through without external feedback wiring.

Parameters:
WIDTH, 16, operand/result width in bits (>= 2)

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
IN_VALID  input  1  upstream offers A/B/OP/CHAIN this cycle
IN_READY  output  1  block can accept an input this cycle
A  input  WIDTH  operand A (ignored when CHAIN=1)
B  input  WIDTH  operand B
OP  input  3  operation select (encoding below)
CHAIN  input  1  1: effective A = ACC (last accepted result)
OUT_VALID  output  1  OUT/ZR/NG hold a valid result
OUT_READY  input  1  downstream consumes result this cycle
OUT  output  WIDTH  registered result
ZR  output  1  1 when OUT == 0
NG  output  1  OUT[WIDTH-1]

Behaviour:
- Reset (RST_N=0, asynchronous, any time including mid-transfer):
  - OUT_VALID=0, OUT=0, ZR=1, NG=0, ACC=0.
  - IN_READY is 1 once RST_N=1, since the output register is empty.
  - Release is synchronous to CLK on the first edge after deassertion.
- OP encoding, with EA = effective A:
  - 0 AND: EA&B
  - 1 OR: EA|B
  - 2 XOR: EA^B
  - 3 NAND: ~(EA&B)
  - 4 NOR: ~(EA|B)
  - 5 XNOR: ~(EA^B)
  - 6 NOT: ~EA (B ignored)
  - 7 PASS: EA (B ignored)
- Width rule: all operations are purely bitwise at WIDTH bits; no carries, no sign extension.
- Handshake:
  - accept = IN_VALID & IN_READY.
  - deliver = OUT_VALID & OUT_READY.
  - IN_READY = ~OUT_VALID | OUT_READY (combinational; allows back-to-back throughput).
- On accept (rising edge):
  - OUT <= f(EA, B, OP).
  - ZR/NG are updated from the new result.
  - OUT_VALID <= 1.
  - ACC <= same result.
- Deliver without accept: OUT_VALID <= 0. OUT, ZR, NG and ACC keep their values.
- Deliver and accept in the same cycle: new result loaded, OUT_VALID stays 1. One result per cycle sustained.
- Latency: 1 cycle. A result accepted at edge N is visible on OUT with OUT_VALID=1 immediately after edge N.
- Backpressure:
  - While OUT_VALID=1 and OUT_READY=0: OUT, ZR, NG and OUT_VALID are held stable, and IN_READY=0.
  - Upstream must hold its inputs. No data is dropped or duplicated.
- IN_VALID=0: no state change other than deliver.
- CHAIN:
  - Sampled only on accept.
  - ACC updates on every accept regardless of CHAIN, so a CHAIN=1 input always uses the immediately preceding accepted result, even if that result has not yet been delivered.
  - The first CHAIN=1 input after reset uses ACC=0.
- X-safety: inputs are don't-care when IN_VALID=0; OUT must not change in that case.
- No internal state machine beyond the OUT_VALID bit and ACC. Only the output register and ACC are sequential.

Test Plan:
- Reset then AND, WIDTH=16:
  - Stimulus: A=16'hF0F0, B=16'h0FF0, OP=0, OUT_READY=1.
  - Response: one cycle later OUT=16'h00F0, ZR=0, NG=0, OUT_VALID=1. Before any accept: OUT=0, ZR=1, OUT_VALID=0.
- NAND of all ones:
  - Stimulus: A=B=16'hFFFF, OP=3.
  - Response: OUT=16'h0000, ZR=1, NG=0.
  - Follow-up: NOR of 0,0 gives OUT=16'hFFFF, NG=1, ZR=0.
- Backpressure:
  - Stimulus: OUT_READY=0; offer XOR 16'h1234^16'h00FF, then hold a second offer OR 16'h0001|16'h0002.
  - Response: OUT=16'h12CB held for 3 stalled cycles with IN_READY=0.
  - Then OUT_READY=1: same cycle IN_READY=1, next edge OUT=16'h0003. Exactly two results are delivered.
- Chain:
  - Stimulus: AND 16'hFFFF & 16'h00FF, then CHAIN=1 OR B=16'h8000, then CHAIN=1 NOT.
  - Response: results 16'h00FF, 16'h80FF (NG=1), 16'h7F00, delivered on back-to-back cycles.
- Reset mid-stream:
  - Stimulus: assert RST_N=0 between edges while OUT_VALID=1 and OUT_READY=0.
  - Response: OUT_VALID=0, OUT=0, ZR=1 immediately (asynchronous). A subsequent CHAIN=1 PASS yields 0.
- Width sweep:
  - Instantiate WIDTH=8 and WIDTH=32, each fed 1000 random accepted inputs with random OUT_READY.
  - Response: each delivered result matches the reference model in order, and ZR/NG are correct.

Source files
------------

// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle for logic_unit_pipe: input offer (operands/op/chain) and registered result.
// master drives the offer and OUT_READY; slave is the pipeline stage.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       OP;
  logic             CHAIN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT;
  logic             ZR;
  logic             NG;

  modport master (
    output IN_VALID, A, B, OP, CHAIN, OUT_READY,
    input  IN_READY, OUT_VALID, OUT, ZR, NG
  );

  modport slave (
    input  IN_VALID, A, B, OP, CHAIN, OUT_READY,
    output IN_READY, OUT_VALID, OUT, ZR, NG
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// One-stage registered bitwise logic unit with valid/ready on both sides,
// zero/negative flags, and a chain mode that feeds the last accepted result back as operand A.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  logic_unit_pipe_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_acc;
  logic             r_valid;
  logic             r_zr;
  logic             r_ng;

  logic [WIDTH-1:0] w_ea;
  logic [WIDTH-1:0] w_res;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_deliver;

  // Slot is free when empty or being drained this cycle, giving full throughput.
  assign w_in_ready = ~r_valid | bus.OUT_READY;
  assign w_accept   = bus.IN_VALID & w_in_ready;
  assign w_deliver  = r_valid & bus.OUT_READY;
  assign w_ea       = bus.CHAIN ? r_acc : bus.A;

  always_comb begin
    w_res = w_ea;
    case (op_e'(bus.OP))
      OP_AND:  w_res = w_ea & bus.B;
      OP_OR:   w_res = w_ea | bus.B;
      OP_XOR:  w_res = w_ea ^ bus.B;
      OP_NAND: w_res = ~(w_ea & bus.B);
      OP_NOR:  w_res = ~(w_ea | bus.B);
      OP_XNOR: w_res = ~(w_ea ^ bus.B);
      OP_NOT:  w_res = ~w_ea;
      OP_PASS: w_res = w_ea;
      default: w_res = w_ea;
    endcase
  end

  // ACC tracks every accepted result so chaining never waits on delivery.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_out   <= '0;
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_zr    <= 1'b1;
      r_ng    <= 1'b0;
    end else if (w_accept) begin
      r_out   <= w_res;
      r_acc   <= w_res;
      r_valid <= 1'b1;
      r_zr    <= (w_res == '0);
      r_ng    <= w_res[WIDTH-1];
    end else if (w_deliver) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.IN_READY  = w_in_ready;
  assign bus.OUT_VALID = r_valid;
  assign bus.OUT       = r_out;
  assign bus.ZR        = r_zr;
  assign bus.NG        = r_ng;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: WIDTH=16 directed vectors and corner sequences,
// plus random width sweeps at 8 and 32 bits, all backed by in-order scoreboards.
module tb_logic_unit_pipe;

  logic clk;
  logic rst_n;
  logic rst_n_w;
  int   total;
  int   bad;
  logic done8;
  logic done32;

  logic_unit_pipe_if #(.WIDTH(16)) bus16 ();
  logic_unit_pipe_if #(.WIDTH(8))  bus8 ();
  logic_unit_pipe_if #(.WIDTH(32)) bus32 ();

  logic_unit_pipe #(.WIDTH(16)) dut16 (.CLK(clk), .RST_N(rst_n),   .bus(bus16));
  logic_unit_pipe #(.WIDTH(8))  dut8  (.CLK(clk), .RST_N(rst_n_w), .bus(bus8));
  logic_unit_pipe #(.WIDTH(32)) dut32 (.CLK(clk), .RST_N(rst_n_w), .bus(bus32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] ea, input logic [31:0] b,
                                        input logic [2:0] op, input int w);
    logic [31:0] r;
    logic [32:0] m;
    case (op)
      3'd0:    r = ea & b;
      3'd1:    r = ea | b;
      3'd2:    r = ea ^ b;
      3'd3:    r = ~(ea & b);
      3'd4:    r = ~(ea | b);
      3'd5:    r = ~(ea ^ b);
      3'd6:    r = ~ea;
      default: r = ea;
    endcase
    m = (33'd1 << w) - 33'd1;
    return r & m[31:0];
  endfunction

  // Scoreboards: push the modelled result on accept, pop and compare on deliver.
  logic [31:0] q16[$];
  logic [31:0] q8[$];
  logic [31:0] q32[$];
  logic [31:0] acc16, acc8, acc32;
  logic [31:0] e16, e8, e32;
  int deliv16, deliv8, deliv32;

  initial begin
    deliv16 = 0; deliv8 = 0; deliv32 = 0;
    acc16 = 0; acc8 = 0; acc32 = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q16.delete();
      acc16 = 0;
    end else begin
      if (bus16.OUT_VALID && bus16.OUT_READY) begin
        chk("sb16_nonempty", 32'(q16.size() != 0), 32'd1);
        if (q16.size() != 0) begin
          e16 = q16.pop_front();
          chk("sb16_out", 32'(bus16.OUT), e16);
          chk("sb16_zr", 32'(bus16.ZR), 32'(e16 == 0));
          chk("sb16_ng", 32'(bus16.NG), 32'(e16[15]));
        end
        deliv16++;
      end
      if (bus16.IN_VALID && bus16.IN_READY) begin
        e16 = model(bus16.CHAIN ? acc16 : 32'(bus16.A), 32'(bus16.B), bus16.OP, 16);
        acc16 = e16;
        q16.push_back(e16);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n_w) begin
      q8.delete();
      acc8 = 0;
    end else begin
      if (bus8.OUT_VALID && bus8.OUT_READY) begin
        chk("sb8_nonempty", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) begin
          e8 = q8.pop_front();
          chk("sb8_out", 32'(bus8.OUT), e8);
          chk("sb8_zr", 32'(bus8.ZR), 32'(e8 == 0));
          chk("sb8_ng", 32'(bus8.NG), 32'(e8[7]));
        end
        deliv8++;
      end
      if (bus8.IN_VALID && bus8.IN_READY) begin
        e8 = model(bus8.CHAIN ? acc8 : 32'(bus8.A), 32'(bus8.B), bus8.OP, 8);
        acc8 = e8;
        q8.push_back(e8);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n_w) begin
      q32.delete();
      acc32 = 0;
    end else begin
      if (bus32.OUT_VALID && bus32.OUT_READY) begin
        chk("sb32_nonempty", 32'(q32.size() != 0), 32'd1);
        if (q32.size() != 0) begin
          e32 = q32.pop_front();
          chk("sb32_out", bus32.OUT, e32);
          chk("sb32_zr", 32'(bus32.ZR), 32'(e32 == 0));
          chk("sb32_ng", 32'(bus32.NG), 32'(e32[31]));
        end
        deliv32++;
      end
      if (bus32.IN_VALID && bus32.IN_READY) begin
        e32 = model(bus32.CHAIN ? acc32 : bus32.A, bus32.B, bus32.OP, 32);
        acc32 = e32;
        q32.push_back(e32);
      end
    end
  end

  // Random sweep drivers: hold an offer until accepted, reroll otherwise.
  initial begin : drv8
    int  n;
    int  cyc;
    logic took;
    done8 = 1'b0;
    bus8.IN_VALID = 1'b0; bus8.OUT_READY = 1'b0; bus8.A = '0; bus8.B = '0;
    bus8.OP = '0; bus8.CHAIN = 1'b0;
    rst_n_w = 1'b0;
    #22 rst_n_w = 1'b1;
    @(posedge clk); #1;
    n = 0; cyc = 0;
    while (n < 1000 && cyc < 20000) begin
      if (!bus8.IN_VALID) begin
        bus8.IN_VALID = ($urandom_range(0, 3) != 0);
        bus8.A = 8'($urandom); bus8.B = 8'($urandom);
        bus8.OP = 3'($urandom); bus8.CHAIN = 1'($urandom);
      end
      bus8.OUT_READY = 1'($urandom);
      @(negedge clk);
      took = bus8.IN_VALID && bus8.IN_READY;
      if (took) n++;
      @(posedge clk); #1;
      if (took) bus8.IN_VALID = 1'b0;
      cyc++;
    end
    chk("sw8_accepts", 32'(n), 32'd1000);
    bus8.IN_VALID = 1'b0; bus8.OUT_READY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sw8_drained", 32'(q8.size()), 32'd0);
    chk("sw8_delivered", 32'(deliv8), 32'd1000);
    done8 = 1'b1;
  end

  initial begin : drv32
    int  n;
    int  cyc;
    logic took;
    done32 = 1'b0;
    bus32.IN_VALID = 1'b0; bus32.OUT_READY = 1'b0; bus32.A = '0; bus32.B = '0;
    bus32.OP = '0; bus32.CHAIN = 1'b0;
    #23;
    @(posedge clk); #1;
    n = 0; cyc = 0;
    while (n < 1000 && cyc < 20000) begin
      if (!bus32.IN_VALID) begin
        bus32.IN_VALID = ($urandom_range(0, 3) != 0);
        bus32.A = $urandom; bus32.B = $urandom;
        bus32.OP = 3'($urandom); bus32.CHAIN = 1'($urandom);
      end
      bus32.OUT_READY = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      took = bus32.IN_VALID && bus32.IN_READY;
      if (took) n++;
      @(posedge clk); #1;
      if (took) bus32.IN_VALID = 1'b0;
      cyc++;
    end
    chk("sw32_accepts", 32'(n), 32'd1000);
    bus32.IN_VALID = 1'b0; bus32.OUT_READY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sw32_drained", 32'(q32.size()), 32'd0);
    chk("sw32_delivered", 32'(deliv32), 32'd1000);
    done32 = 1'b1;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        chain;
    logic [15:0] out;
    logic        zr;
    logic        ng;
  } vec_t;

  vec_t vt[12];
  int   base;

  initial begin : main
    total = 0; bad = 0;
    vt[0]  = '{16'hF0F0, 16'h0FF0, 3'd0, 1'b0, 16'h00F0, 1'b0, 1'b0};
    vt[1]  = '{16'hFFFF, 16'hFFFF, 3'd3, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2]  = '{16'h0000, 16'h0000, 3'd4, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    vt[3]  = '{16'hAAAA, 16'h5555, 3'd1, 1'b0, 16'hFFFF, 1'b0, 1'b1};
    vt[4]  = '{16'h1234, 16'h00FF, 3'd2, 1'b0, 16'h12CB, 1'b0, 1'b0};
    vt[5]  = '{16'h1234, 16'h00FF, 3'd5, 1'b0, 16'hED34, 1'b0, 1'b1};
    vt[6]  = '{16'h00FF, 16'hBEEF, 3'd6, 1'b0, 16'hFF00, 1'b0, 1'b1};
    vt[7]  = '{16'h8001, 16'h1111, 3'd7, 1'b0, 16'h8001, 1'b0, 1'b1};
    vt[8]  = '{16'hFFFF, 16'h00FF, 3'd0, 1'b0, 16'h00FF, 1'b0, 1'b0};
    vt[9]  = '{16'hDEAD, 16'h8000, 3'd1, 1'b1, 16'h80FF, 1'b0, 1'b1};
    vt[10] = '{16'hDEAD, 16'h1234, 3'd6, 1'b1, 16'h7F00, 1'b0, 1'b0};
    vt[11] = '{16'hCAFE, 16'h7F00, 3'd2, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0;
    bus16.IN_VALID = 1'b0; bus16.OUT_READY = 1'b0; bus16.A = '0; bus16.B = '0;
    bus16.OP = '0; bus16.CHAIN = 1'b0;
    #12;
    chk("rst_out", 32'(bus16.OUT), 32'h0);
    chk("rst_zr", 32'(bus16.ZR), 32'd1);
    chk("rst_ng", 32'(bus16.NG), 32'd0);
    chk("rst_valid", 32'(bus16.OUT_VALID), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(bus16.IN_READY), 32'd1);
    chk("idle_valid", 32'(bus16.OUT_VALID), 32'd0);

    // Directed vectors, one accept per cycle with the sink always ready.
    bus16.OUT_READY = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus16.IN_VALID = 1'b1;
      bus16.A = vt[i].a; bus16.B = vt[i].b; bus16.OP = vt[i].op; bus16.CHAIN = vt[i].chain;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out", i), 32'(bus16.OUT), 32'(vt[i].out));
      chk($sformatf("vec%0d_zr", i), 32'(bus16.ZR), 32'(vt[i].zr));
      chk($sformatf("vec%0d_ng", i), 32'(bus16.NG), 32'(vt[i].ng));
      chk($sformatf("vec%0d_valid", i), 32'(bus16.OUT_VALID), 32'd1);
    end
    bus16.IN_VALID = 1'b0;
    bus16.A = 16'h5A5A; bus16.B = 16'hA5A5; bus16.OP = 3'd1;
    @(posedge clk); #1;
    chk("drain_valid", 32'(bus16.OUT_VALID), 32'd0);
    chk("drain_out_held", 32'(bus16.OUT), 32'h0000);
    chk("drain_zr_held", 32'(bus16.ZR), 32'd1);

    // Backpressure: XOR result stalls three cycles while OR waits upstream.
    base = deliv16;
    bus16.OUT_READY = 1'b0;
    bus16.IN_VALID = 1'b1; bus16.A = 16'h1234; bus16.B = 16'h00FF; bus16.OP = 3'd2;
    bus16.CHAIN = 1'b0;
    #1;
    chk("bp_ready_empty", 32'(bus16.IN_READY), 32'd1);
    @(posedge clk); #1;
    chk("bp_first_out", 32'(bus16.OUT), 32'h12CB);
    bus16.A = 16'h0001; bus16.B = 16'h0002; bus16.OP = 3'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_stall%0d_ready", k), 32'(bus16.IN_READY), 32'd0);
      chk($sformatf("bp_stall%0d_out", k), 32'(bus16.OUT), 32'h12CB);
      chk($sformatf("bp_stall%0d_valid", k), 32'(bus16.OUT_VALID), 32'd1);
      @(posedge clk); #1;
    end
    chk("bp_held_out", 32'(bus16.OUT), 32'h12CB);
    bus16.OUT_READY = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus16.IN_READY), 32'd1);
    @(posedge clk); #1;
    chk("bp_second_out", 32'(bus16.OUT), 32'h0003);
    chk("bp_second_valid", 32'(bus16.OUT_VALID), 32'd1);
    bus16.IN_VALID = 1'b0;
    @(posedge clk); #1;
    chk("bp_end_valid", 32'(bus16.OUT_VALID), 32'd0);
    chk("bp_delivered", 32'(deliv16 - base), 32'd2);

    // Asynchronous reset while a result is stalled; ACC must also clear.
    bus16.OUT_READY = 1'b0;
    bus16.IN_VALID = 1'b1; bus16.A = 16'hFFFF; bus16.B = 16'hFFFF; bus16.OP = 3'd0;
    bus16.CHAIN = 1'b0;
    @(posedge clk); #1;
    chk("mr_pre_out", 32'(bus16.OUT), 32'hFFFF);
    bus16.IN_VALID = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(bus16.OUT_VALID), 32'd0);
    chk("mr_out", 32'(bus16.OUT), 32'h0);
    chk("mr_zr", 32'(bus16.ZR), 32'd1);
    chk("mr_ng", 32'(bus16.NG), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    bus16.OUT_READY = 1'b1;
    bus16.IN_VALID = 1'b1; bus16.A = 16'h1234; bus16.B = 16'h5678; bus16.OP = 3'd7;
    bus16.CHAIN = 1'b1;
    @(posedge clk); #1;
    chk("mr_chain_out", 32'(bus16.OUT), 32'h0);
    chk("mr_chain_zr", 32'(bus16.ZR), 32'd1);
    chk("mr_chain_valid", 32'(bus16.OUT_VALID), 32'd1);
    bus16.IN_VALID = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 30000 && !(done8 && done32); k++) @(posedge clk);
    chk("sweep_done", 32'(done8 && done32), 32'd1);
    chk("sb16_empty_end", 32'(q16.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
